// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the RV32I core.
// Owns the program counter, runs a req/ack handshake with instruction memory
// and hands a registered instruction word plus its PC to the decoder.
// A fetch that is already in flight when a redirect arrives is allowed to
// complete (KILL) so the memory never sees overlapping requests.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   output logic        misaligned_err
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      HOLD,
      KILL,
      HALT
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pending_pc;
   logic        bad_redirect;

   // A redirect whose target is not word aligned halts the fetch unit.
   assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);

   // The fetch address is always the program counter register itself.
   assign imem_addr = pc;

   // Fetch state machine; all outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         pending_pc     <= RESET_PC;
         imem_req       <= 1'b0;
         instr_out      <= NOP_INSTR;
         pc_out         <= RESET_PC;
         instr_valid    <= 1'b0;
         misaligned_err <= 1'b0;
      end else if (state != HALT && bad_redirect) begin
         state          <= HALT;
         misaligned_err <= 1'b1;
         instr_valid    <= 1'b0;
         imem_req       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               if (imem_ack) begin
                  if (redirect_valid) begin
                     pc       <= redirect_pc;
                     state    <= REQ;
                     imem_req <= 1'b1;
                  end else begin
                     instr_out   <= imem_rdata;
                     pc_out      <= pc;
                     instr_valid <= 1'b1;
                     imem_req    <= 1'b0;
                     state       <= HOLD;
                  end
               end else if (redirect_valid) begin
                  pending_pc <= redirect_pc;
                  state      <= KILL;
               end
            end
            KILL: begin
               if (redirect_valid) begin
                  pending_pc <= redirect_pc;
               end
               if (imem_ack) begin
                  pc       <= redirect_valid ? redirect_pc : pending_pc;
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  instr_valid <= 1'b0;
                  instr_out   <= NOP_INSTR;
                  pc          <= redirect_pc;
                  imem_req    <= 1'b1;
                  state       <= REQ;
               end else if (!stall) begin
                  instr_valid <= 1'b0;
                  pc          <= pc + 32'd4;
                  imem_req    <= 1'b1;
                  state       <= REQ;
               end
            end
            HALT: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
            default: begin
               state       <= HALT;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
